// File: rtl/rd_deserializer_if.sv
// rd_deserializer_if: single-cycle write port into the RD event buffer.
interface rd_deserializer_if #(parameter int ADDR_W = 11);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data0;
  logic [11:0]       wr_data1;
  logic              perr0;
  logic              perr1;
  modport master (output wr_en, wr_addr, wr_data0, wr_data1, perr0, perr1);
  modport slave  (input  wr_en, wr_addr, wr_data0, wr_data1, perr0, perr1);
endinterface

// File: rtl/rd_deserializer.sv
// rd_deserializer: frames two RD serial lanes (12 data bits MSB first + odd parity) into buffer writes.
// Optional RD_PATTERN_CHECK_EN adds pattern_err_count against the fake RD source ramp.
module rd_deserializer #(
  parameter int NUM_WORDS = 2048,
  parameter int ADDR_W    = 11,
  parameter int PRE_CLKS  = 3,
  parameter int TIMEOUT   = 1024,
  parameter int TIMEOUT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              arm,
  input  logic              xfr_clk,
  input  logic              serial_in0,
  input  logic              serial_in1,
  rd_deserializer_if.master wr,
  output logic [15:0]       perr_count,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
`ifdef RD_PATTERN_CHECK_EN
  ,
  output logic [15:0]       pattern_err_count
`endif
);
  typedef enum logic [1:0] {IDLE, SKIP, SHIFT} state_t;
  state_t                 state;
  logic [2:0]             xs;
  logic [1:0]             s0, s1;
  logic                   ev, p0, p1, x0, x1;
  logic [11:0]            sh0, sh1;
  logic [3:0]             bit_cnt;
  logic [7:0]             skip_cnt;
  logic [ADDR_W-1:0]      word_cnt;
  logic [TIMEOUT_W-1:0]   idle_cnt;
  assign ev   = xs[1] & ~xs[2];
  assign busy = state != IDLE;
  assign p0   = ~(x0 ^ s0[1]);
  assign p1   = ~(x1 ^ s1[1]);
  // lanes share the clock's sync depth so the edge-event cycle sees the matching data bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      xs <= '1;
      s0 <= '1;
      s1 <= '1;
    end else begin
      xs <= {xs[1:0], xfr_clk};
      s0 <= {s0[0], serial_in0};
      s1 <= {s1[0], serial_in1};
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      wr.wr_en    <= 1'b0;
      wr.wr_addr  <= '0;
      wr.wr_data0 <= '0;
      wr.wr_data1 <= '0;
      wr.perr0    <= 1'b0;
      wr.perr1    <= 1'b0;
      perr_count  <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      sh0         <= '0;
      sh1         <= '0;
      x0          <= 1'b0;
      x1          <= 1'b0;
      bit_cnt     <= '0;
      skip_cnt    <= '0;
      word_cnt    <= '0;
      idle_cnt    <= '0;
`ifdef RD_PATTERN_CHECK_EN
      pattern_err_count <= '0;
`endif
    end else begin
      wr.wr_en <= 1'b0;
      done     <= 1'b0;
      if (!enable) state <= IDLE;
      else if (state == IDLE) begin
        if (arm) begin
          state       <= SKIP;
          perr_count  <= '0;
          timeout_err <= 1'b0;
          bit_cnt     <= '0;
          skip_cnt    <= '0;
          word_cnt    <= '0;
          idle_cnt    <= '0;
          x0          <= 1'b0;
          x1          <= 1'b0;
`ifdef RD_PATTERN_CHECK_EN
          pattern_err_count <= '0;
`endif
        end
      end else if (ev) begin
        idle_cnt <= '0;
        if (state == SKIP) begin
          skip_cnt <= skip_cnt + 8'd1;
          if (skip_cnt == 8'(PRE_CLKS - 1)) state <= SHIFT;
        end else if (bit_cnt == 4'd12) begin
          wr.wr_en    <= 1'b1;
          wr.wr_addr  <= word_cnt;
          wr.wr_data0 <= sh0;
          wr.wr_data1 <= sh1;
          wr.perr0    <= p0;
          wr.perr1    <= p1;
          if ((p0 | p1) && perr_count != 16'hFFFF) perr_count <= perr_count + 16'd1;
`ifdef RD_PATTERN_CHECK_EN
          if ((sh0 != 12'(word_cnt) || sh1 != 12'd0 - 12'(word_cnt)) && pattern_err_count != 16'hFFFF)
            pattern_err_count <= pattern_err_count + 16'd1;
`endif
          x0       <= 1'b0;
          x1       <= 1'b0;
          bit_cnt  <= '0;
          word_cnt <= word_cnt + 1'b1;
          if (word_cnt == ADDR_W'(NUM_WORDS - 1)) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end else begin
          sh0     <= {sh0[10:0], s0[1]};
          sh1     <= {sh1[10:0], s1[1]};
          x0      <= x0 ^ s0[1];
          x1      <= x1 ^ s1[1];
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (idle_cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
        timeout_err <= 1'b1;
        done        <= 1'b1;
        state       <= IDLE;
      end else idle_cnt <= idle_cnt + 1'b1;
    end
endmodule

// File: tb/tb_rd_deserializer.sv
// tb_rd_deserializer: randomized RD serial transfers checked by a write scoreboard.
module tb_rd_deserializer;
  localparam int NW = 4;
  localparam int AW = 2;
  localparam int TO = 64;
  logic clk = 0, rst_n = 0, enable = 0, arm = 0, xfr_clk = 0, serial_in0 = 1, serial_in1 = 1;
  logic [15:0] perr_count;
  logic busy, done, timeout_err;
`ifdef RD_PATTERN_CHECK_EN
  logic [15:0] pattern_err_count;
`endif
  rd_deserializer_if #(.ADDR_W(AW)) wr();
  rd_deserializer #(.NUM_WORDS(NW), .ADDR_W(AW), .PRE_CLKS(3), .TIMEOUT(TO), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .arm(arm), .xfr_clk(xfr_clk),
    .serial_in0(serial_in0), .serial_in1(serial_in1), .wr(wr.master),
    .perr_count(perr_count), .busy(busy), .done(done), .timeout_err(timeout_err)
`ifdef RD_PATTERN_CHECK_EN
    , .pattern_err_count(pattern_err_count)
`endif
  );
  typedef struct {int addr; logic [11:0] d0; logic [11:0] d1; logic p0; logic p1;} wr_t;
  wr_t exp_q[$];
  wr_t e;
  int checks = 0, errors = 0, done_cnt = 0, exp_perr = 0, exp_pat = 0;
  time t_last;
  logic [11:0] w0[NW], w1[NW];
  logic f0[NW], f1[NW];
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (wr.wr_en) begin
      chk("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", wr.wr_addr, e.addr);
        chk("wr_data0", wr.wr_data0, e.d0);
        chk("wr_data1", wr.wr_data1, e.d1);
        chk("perr0", wr.perr0, e.p0);
        chk("perr1", wr.perr1, e.p1);
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_cause", wr.wr_en | timeout_err, 1);
    end
  end
  task automatic edge_(input logic b0, input logic b1);
    xfr_clk = 0;
    serial_in0 = b0;
    serial_in1 = b1;
    #40;
    xfr_clk = 1;
    t_last = $time;
    #40;
  endtask
  task automatic do_arm();
    @(negedge clk) arm = 1;
    @(negedge clk) arm = 0;
  endtask
  // stop_bits >= 0 cuts the stream after that many data/parity edges
  task automatic xfer(input int stop_bits, input bit arm_mid);
    int n = 0;
    done_cnt = 0; exp_perr = 0; exp_pat = 0;
    do_arm();
    repeat (3) edge_(1'($urandom), 1'($urandom));
    for (int k = 0; k < NW; k++)
      for (int b = 0; b <= 12; b++) begin
        if (stop_bits >= 0 && n == stop_bits) return;
        if (arm_mid && k == 1 && b == 4) fork begin do_arm(); end join_none
        if (b < 12) edge_(w0[k][11-b], w1[k][11-b]);
        else begin
          exp_q.push_back('{k, w0[k], w1[k], f0[k], f1[k]});
          exp_perr += int'(f0[k] | f1[k]);
          exp_pat += int'(w0[k] != 12'(k) || w1[k] != 12'(-k));
          edge_((~^w0[k]) ^ f0[k], (~^w1[k]) ^ f1[k]);
        end
        n++;
      end
  endtask
  task automatic fill(input bit rnd);
    for (int k = 0; k < NW; k++) begin
      w0[k] = rnd ? 12'($urandom) : 12'(k);
      w1[k] = rnd ? 12'($urandom) : 12'(-k);
      f0[k] = rnd ? ($urandom_range(3) == 0) : 1'b0;
      f1[k] = rnd ? ($urandom_range(3) == 0) : 1'b0;
    end
  endtask
  task automatic end_chk(input string n, input int ndone, input logic to);
    repeat (12) @(negedge clk);
    chk({n, "_queue_drained"}, exp_q.size(), 0);
    chk({n, "_done_count"}, done_cnt, ndone);
    chk({n, "_perr_count"}, perr_count, exp_perr);
    chk({n, "_timeout_err"}, timeout_err, to);
    chk({n, "_busy"}, busy, 0);
`ifdef RD_PATTERN_CHECK_EN
    chk({n, "_pattern_err_count"}, pattern_err_count, exp_pat);
`endif
  endtask
  initial begin
    int lat;
    #23;
    chk("rst_wr_en", wr.wr_en, 0);
    chk("rst_wr_addr", wr.wr_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_perr_count", perr_count, 0);
    chk("rst_timeout_err", timeout_err, 0);
    @(negedge clk) rst_n = 1;
    enable = 1;
    fill(0);
    xfer(-1, 0);
    end_chk("ramp", 1, 0);
    f1[2] = 1;
    xfer(-1, 0);
    end_chk("parity", 1, 0);
    f1[2] = 0;
    w0[3] = 12'h007;
    xfer(-1, 0);
    end_chk("pattern", 1, 0);
    fill(1);
    xfer(-1, 1);
    end_chk("arm_mid", 1, 0);
    repeat (4) begin
      fill(1);
      xfer(-1, 0);
      end_chk("random", 1, 0);
    end
    fill(1);
    xfer(13 + 8, 0);
    lat = 0;
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    lat = int'(($time - t_last) / 10);
    chk("timeout_latency_ok", lat >= TO && lat <= TO + 4, 1);
    end_chk("timeout", 1, 1);
    fill(1);
    xfer(13 + 6, 0);
    @(negedge clk) enable = 0;
    @(negedge clk);
    chk("enable_drop_busy", busy, 0);
    repeat (3) @(negedge clk);
    enable = 1;
    repeat (20) edge_(1'($urandom), 1'($urandom));
    end_chk("enable_drop", 0, 0);
    fill(1);
    xfer(-1, 0);
    end_chk("rearm", 1, 0);
    fill(1);
    w0[0] = w0[0] | 12'h001;
    f0[0] = 1;
    xfer(13 + 5, 0);
    #3 rst_n = 0;
    #1;
    chk("rstmid_wr_en", wr.wr_en, 0);
    chk("rstmid_wr_addr", wr.wr_addr, 0);
    chk("rstmid_wr_data0", wr.wr_data0, 0);
    chk("rstmid_wr_data1", wr.wr_data1, 0);
    chk("rstmid_perr0", wr.perr0, 0);
    chk("rstmid_perr1", wr.perr1, 0);
    chk("rstmid_perr_count", perr_count, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_timeout_err", timeout_err, 0);
    chk("rstmid_queue", exp_q.size(), 0);
    @(negedge clk) rst_n = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
